// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (16x oversampling) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o pulse.
module uart_rx_fifo #(
  parameter int Depth    = 16,
  parameter int DivWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_i,
  input  logic [DivWidth-1:0]    div_i,
  output logic [7:0]             rdata_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [$clog2(Depth):0] level_o,
  output logic                   frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err_o,
`endif
  output logic                   overflow_o,
  input  logic                   clear_i
);
  localparam int AW = $clog2(Depth);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic                sync1, rxs, rxs_prev;
  logic [DivWidth-1:0] cnt, reload;
  logic                tick;
  logic [3:0]          os;
  logic [2:0]          idx;
  logic [7:0]          shift;
  logic                stop_tick, push;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx_i;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  assign reload = (div_i == '0) ? '0 : div_i - DivWidth'(1);
  assign tick   = (state != IDLE) && (cnt == '0);

  // Held at reload while idle so the first tick lands div cycles after the start edge
  always_ff @(posedge clk_i) begin
    if (rst_i)                          cnt <= '0;
    else if (state == IDLE || cnt == '0) cnt <= reload;
    else                                cnt <= cnt - DivWidth'(1);
  end

  assign stop_tick = (state == STOP) && tick && (os == 4'd15);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign push = stop_tick && rxs && !par_bad;
`else
  assign push = stop_tick && rxs;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      os          <= '0;
      idx         <= '0;
      shift       <= '0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rxs_prev && !rxs) begin
            state <= START;
            os    <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os == 4'd7) begin
              os    <= '0;
              idx   <= '0;
              state <= rxs ? IDLE : DATA;
            end else begin
              os <= os + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            os <= os + 4'd1;
            if (os == 4'd15) begin
              shift[idx] <= rxs;
              idx        <= idx + 3'd1;
              if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            os <= os + 4'd1;
            if (os == 4'd15) begin
              par_bad <= (rxs != ^shift);
              state   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            os <= os + 4'd1;
            if (os == 4'd15) begin
              frame_err_o <= !rxs;
`ifdef UART_RX_PARITY_EN
              parity_err_o <= par_bad;
`endif
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]  mem [Depth];
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, wr;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rvalid_o = !empty;
  assign pop      = rvalid_o && rready_i;
  assign wr       = push && (!full || pop);
  assign rdata_o  = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr       <= '0;
      rptr       <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      level_o <= (wptr + (AW+1)'(wr)) - (rptr + (AW+1)'(pop));
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  end

endmodule
